// File: rtl/rotor_pkg.sv
// Shared types and constants for the rotary shaft encoder emulator.
package rotor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PH1,
        PH2,
        PH3,
        PH4,
        PRESS,
        RELEASE
    } rotor_state_e;

    localparam logic DIR_CW    = 1'b1;
    localparam logic DIR_CCW   = 1'b0;
    localparam logic LINE_IDLE = 1'b0;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits++;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/rotor_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying contact chatter.
module rotor_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic chatter
);

    logic [15:0] q;
    logic        feedback;

    assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];
    assign chatter  = q[0];

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (enable) begin
            q <= {q[14:0], feedback};
        end
    end

endmodule

// File: rtl/rotor_emulator.sv
// Emulates the rotary encoder's A/B quadrature and centre-button lines from a
// command handshake, with optional chatter on the line that changes.
module rotor_emulator
    import rotor_pkg::*;
#(
    parameter int          PHASE_CYCLES  = 50000,
    parameter int          BOUNCE_CYCLES = 0,
    parameter int          PRESS_CYCLES  = 500000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic CLK50MHZ,
    input  logic RST,
    input  logic cmd_valid,
    output logic cmd_ready,
    input  logic cmd_press,
    input  logic cmd_dir,
    output logic done,
    output logic ROT_A,
    output logic ROT_B,
    output logic ROT_CENTER
);

    localparam int MAX_CYCLES = (PHASE_CYCLES > PRESS_CYCLES) ? PHASE_CYCLES : PRESS_CYCLES;
    localparam int CW         = clog2(MAX_CYCLES);

    localparam logic [CW-1:0] PHASE_LAST  = CW'(PHASE_CYCLES - 1);
    localparam logic [CW-1:0] PRESS_LAST  = CW'(PRESS_CYCLES - 1);
    localparam bit            BOUNCE_EN   = (BOUNCE_CYCLES > 0);
    localparam logic [CW-1:0] BOUNCE_LAST = BOUNCE_EN ? CW'(BOUNCE_CYCLES - 1) : '0;

    rotor_state_e  state, state_next;
    logic [CW-1:0] counter, counter_next;
    logic          dir_q, dir_next;
    logic          a_next, b_next, c_next;
    logic          done_next;
    logic          chatter;

    // Levels expressed in clockwise order (x leads y); mapped onto A/B by direction.
    logic          x_tgt, y_tgt, chg_x, chg_y, chg_c;
    logic          bouncing;

    rotor_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (CLK50MHZ),
        .rst_n   (RST),
        .enable  (1'b1),
        .chatter (chatter)
    );

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        dir_next   = dir_q;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_press) begin
                        state_next = PRESS;
                    end else begin
                        state_next = PH1;
                        dir_next   = cmd_dir;
                    end
                end
            end
            PH1:     if (counter == PHASE_LAST) state_next = PH2;
            PH2:     if (counter == PHASE_LAST) state_next = PH3;
            PH3:     if (counter == PHASE_LAST) state_next = PH4;
            PH4:     if (counter == PHASE_LAST) state_next = IDLE;
            PRESS:   if (counter == PRESS_LAST) state_next = RELEASE;
            RELEASE: if (counter == PRESS_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (state_next != state || state == IDLE) begin
            counter_next = '0;
        end else begin
            counter_next = counter + 1'b1;
        end

        done_next = (state != IDLE) && (state_next == IDLE);
    end

    // Output levels are computed for the cycle being entered, so the registered
    // lines show the new phase at the very edge that enters it.
    always_comb begin
        x_tgt  = LINE_IDLE;
        y_tgt  = LINE_IDLE;
        chg_x  = 1'b0;
        chg_y  = 1'b0;
        chg_c  = 1'b0;
        c_next = LINE_IDLE;
        unique case (state_next)
            PH1:     begin x_tgt = 1'b1; y_tgt = 1'b0; chg_x = 1'b1; end
            PH2:     begin x_tgt = 1'b1; y_tgt = 1'b1; chg_y = 1'b1; end
            PH3:     begin x_tgt = 1'b0; y_tgt = 1'b1; chg_x = 1'b1; end
            PH4:     begin x_tgt = 1'b0; y_tgt = 1'b0; chg_y = 1'b1; end
            PRESS:   begin c_next = 1'b1; chg_c = 1'b1; end
            RELEASE: begin c_next = 1'b0; chg_c = 1'b1; end
            default: ;
        endcase

        bouncing = BOUNCE_EN && (counter_next <= BOUNCE_LAST);

        a_next = (dir_next == DIR_CW) ? x_tgt : y_tgt;
        b_next = (dir_next == DIR_CW) ? y_tgt : x_tgt;
        if (bouncing) begin
            if ((dir_next == DIR_CW) ? chg_x : chg_y) a_next = chatter;
            if ((dir_next == DIR_CW) ? chg_y : chg_x) b_next = chatter;
            if (chg_c) c_next = chatter;
        end
    end

    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            counter    <= '0;
            dir_q      <= DIR_CW;
            ROT_A      <= LINE_IDLE;
            ROT_B      <= LINE_IDLE;
            ROT_CENTER <= LINE_IDLE;
            done       <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            state      <= state_next;
            counter    <= counter_next;
            dir_q      <= dir_next;
            ROT_A      <= a_next;
            ROT_B      <= b_next;
            ROT_CENTER <= c_next;
            done       <= done_next;
            cmd_ready  <= (state_next == IDLE);
        end
    end

endmodule

// File: tb/tb_rotor_emulator.sv
// Randomised self-checking bench: two emulator instances (plain and bouncing)
// checked cycle by cycle against a waveform model and a quadrature counter.
module tb_rotor_emulator;

    localparam int PA = 4;
    localparam int BA = 0;
    localparam int RA = 10;
    localparam int PB = 8;
    localparam int BB = 2;
    localparam int RB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic valid_a, press_a, dir_a;
    logic ready_a, done_a, a_a, b_a, c_a;
    logic valid_b, press_b, dir_b;
    logic ready_b, done_b, a_b, b_b, c_b;

    int checks = 0;
    int errors = 0;

    // Clockwise settled levels per phase; counter-clockwise swaps the lines.
    bit cw_a [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit cw_b [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    rotor_emulator #(
        .PHASE_CYCLES(PA), .BOUNCE_CYCLES(BA), .PRESS_CYCLES(RA), .LFSR_SEED(16'hACE1)
    ) u_dut_a (
        .CLK50MHZ(clk), .RST(rst_n),
        .cmd_valid(valid_a), .cmd_ready(ready_a), .cmd_press(press_a), .cmd_dir(dir_a),
        .done(done_a), .ROT_A(a_a), .ROT_B(b_a), .ROT_CENTER(c_a)
    );

    rotor_emulator #(
        .PHASE_CYCLES(PB), .BOUNCE_CYCLES(BB), .PRESS_CYCLES(RB), .LFSR_SEED(16'h1D0F)
    ) u_dut_b (
        .CLK50MHZ(clk), .RST(rst_n),
        .cmd_valid(valid_b), .cmd_ready(ready_b), .cmd_press(press_b), .cmd_dir(dir_b),
        .done(done_b), .ROT_A(a_b), .ROT_B(b_b), .ROT_CENTER(c_b)
    );

    // Position on the quadrature circle, clockwise order 00,10,11,01.
    function automatic int gray_pos(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Quarter-step contribution of a transition; a double jump counts as nothing.
    function automatic int quarter_delta(input int p0, input int p1);
        int d;
        d = (p1 - p0 + 4) % 4;
        if (d == 1) return 1;
        if (d == 3) return -1;
        return 0;
    endfunction

    task automatic wait_ready_a();
        for (int i = 0; i < 200 && ready_a !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (ready_a !== 1'b1) begin
            errors++;
            $display("FAIL ready_a_timeout got %b want 1", ready_a);
        end
    endtask

    task automatic wait_ready_b();
        for (int i = 0; i < 200 && ready_b !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (ready_b !== 1'b1) begin
            errors++;
            $display("FAIL ready_b_timeout got %b want 1", ready_b);
        end
    endtask

    // One rotate step on the plain instance. hold keeps cmd_valid high for a
    // following back-to-back command; noise drives random cmd_valid while busy.
    task automatic run_step_a(input logic dir, input bit hold, input bit noise);
        int  pos, quarters, ph;
        logic ea, eb;
        wait_ready_a();
        valid_a = 1'b1; press_a = 1'b0; dir_a = dir;
        @(posedge clk); #1;
        if (!hold) valid_a = 1'b0;
        pos = 0; quarters = 0;
        for (int k = 0; k <= 4 * PA; k++) begin
            if (k < 4 * PA) begin
                ph = k / PA;
                ea = dir ? cw_a[ph] : cw_b[ph];
                eb = dir ? cw_b[ph] : cw_a[ph];
            end else begin
                ea = 1'b0; eb = 1'b0;
            end
            checks++;
            if ({a_a, b_a} !== {ea, eb}) begin
                errors++;
                $display("FAIL step_ab k=%0d dir=%b got %b%b want %b%b", k, dir, a_a, b_a, ea, eb);
            end
            checks++;
            if (c_a !== 1'b0) begin
                errors++;
                $display("FAIL step_center k=%0d got %b want 0", k, c_a);
            end
            checks++;
            if (done_a !== (k == 4 * PA) || ready_a !== (k == 4 * PA)) begin
                errors++;
                $display("FAIL step_done_ready k=%0d got %b%b want %b%b",
                         k, done_a, ready_a, k == 4 * PA, k == 4 * PA);
            end
            quarters += quarter_delta(pos, gray_pos(a_a, b_a));
            pos = gray_pos(a_a, b_a);
            if (noise && k < 4 * PA - 1) begin
                valid_a = 1'($urandom_range(0, 1));
                press_a = 1'($urandom_range(0, 1));
                dir_a   = 1'($urandom_range(0, 1));
            end else if (noise) begin
                valid_a = 1'b0;
            end
            if (k < 4 * PA) begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (quarters !== (dir ? 4 : -4)) begin
            errors++;
            $display("FAIL step_count dir=%b got %0d want %0d", dir, quarters, dir ? 4 : -4);
        end
        if (!hold) begin
            valid_a = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (done_a !== 1'b0 || ready_a !== 1'b1 || {a_a, b_a} !== 2'b00) begin
                errors++;
                $display("FAIL step_after got done=%b ready=%b ab=%b%b want 0 1 00",
                         done_a, ready_a, a_a, b_a);
            end
        end
    endtask

    task automatic run_press_a(input logic dir);
        logic ec;
        wait_ready_a();
        valid_a = 1'b1; press_a = 1'b1; dir_a = dir;
        @(posedge clk); #1;
        valid_a = 1'b0;
        for (int k = 0; k <= 2 * RA; k++) begin
            ec = (k < RA);
            checks++;
            if (c_a !== ec || {a_a, b_a} !== 2'b00) begin
                errors++;
                $display("FAIL press_lines k=%0d got c=%b ab=%b%b want c=%b ab=00", k, c_a, a_a, b_a, ec);
            end
            checks++;
            if (done_a !== (k == 2 * RA) || ready_a !== (k == 2 * RA)) begin
                errors++;
                $display("FAIL press_done_ready k=%0d got %b%b want %b%b",
                         k, done_a, ready_a, k == 2 * RA, k == 2 * RA);
            end
            if (k < 2 * RA) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic run_step_b(input logic dir);
        int   pos, quarters, ph, off;
        logic ea, eb;
        bit   chg_is_a;
        wait_ready_b();
        valid_b = 1'b1; press_b = 1'b0; dir_b = dir;
        @(posedge clk); #1;
        valid_b = 1'b0;
        pos = 0; quarters = 0;
        for (int k = 0; k <= 4 * PB; k++) begin
            ph  = (k < 4 * PB) ? k / PB : 0;
            off = k % PB;
            if (k < 4 * PB) begin
                ea = dir ? cw_a[ph] : cw_b[ph];
                eb = dir ? cw_b[ph] : cw_a[ph];
            end else begin
                ea = 1'b0; eb = 1'b0;
            end
            // Even phases move the leading line, odd phases the lagging one.
            chg_is_a = ((ph % 2) == 0) == (dir == 1'b1);
            if (k == 4 * PB || off >= BB) begin
                checks++;
                if ({a_b, b_b} !== {ea, eb}) begin
                    errors++;
                    $display("FAIL bounce_settled k=%0d dir=%b got %b%b want %b%b", k, dir, a_b, b_b, ea, eb);
                end
                quarters += quarter_delta(pos, gray_pos(a_b, b_b));
                pos = gray_pos(a_b, b_b);
            end else begin
                checks++;
                if ((chg_is_a ? b_b : a_b) !== (chg_is_a ? eb : ea) || $isunknown({a_b, b_b})) begin
                    errors++;
                    $display("FAIL bounce_quiet_line k=%0d dir=%b got %b%b want %b%b on the quiet line",
                             k, dir, a_b, b_b, ea, eb);
                end
            end
            checks++;
            if (c_b !== 1'b0 || done_b !== (k == 4 * PB)) begin
                errors++;
                $display("FAIL bounce_step_misc k=%0d got c=%b done=%b want c=0 done=%b",
                         k, c_b, done_b, k == 4 * PB);
            end
            if (k < 4 * PB) begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (quarters !== (dir ? 4 : -4)) begin
            errors++;
            $display("FAIL bounce_count dir=%b got %0d want %0d", dir, quarters, dir ? 4 : -4);
        end
    endtask

    task automatic run_press_b();
        logic ec;
        wait_ready_b();
        valid_b = 1'b1; press_b = 1'b1; dir_b = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        valid_b = 1'b0;
        for (int k = 0; k <= 2 * RB; k++) begin
            ec = (k < RB);
            checks++;
            if ((k % RB >= BB || k == 2 * RB) && c_b !== ec) begin
                errors++;
                $display("FAIL bounce_press_c k=%0d got %b want %b", k, c_b, ec);
            end else if ({a_b, b_b} !== 2'b00 || $isunknown(c_b)) begin
                errors++;
                $display("FAIL bounce_press_ab k=%0d got ab=%b%b c=%b want ab=00", k, a_b, b_b, c_b);
            end
            checks++;
            if (done_b !== (k == 2 * RB)) begin
                errors++;
                $display("FAIL bounce_press_done k=%0d got %b want %b", k, done_b, k == 2 * RB);
            end
            if (k < 2 * RB) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({a_a, b_a, c_a, done_a, ready_a} !== 5'b00001 ||
            {a_b, b_b, c_b, done_b, ready_b} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_state got %b %b want 00001 00001",
                     {a_a, b_a, c_a, done_a, ready_a}, {a_b, b_b, c_b, done_b, ready_b});
        end
    endtask

    task automatic test_cw_step();
        run_step_a(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_ccw_step();
        run_step_a(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_press();
        run_press_a(1'($urandom_range(0, 1)));
    endtask

    task automatic test_busy_ignored();
        for (int i = 0; i < 4; i++) begin
            run_step_a(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        run_step_a(1'b1, 1'b1, 1'b0);
        run_step_a(1'b1, 1'b1, 1'b0);
        run_step_a(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({a_a, b_a, ready_a} !== 3'b001) begin
                errors++;
                $display("FAIL b2b_no_extra i=%0d got ab=%b%b ready=%b want 00 1", i, a_a, b_a, ready_a);
            end
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 4; i++) begin
            run_step_b(1'($urandom_range(0, 1)));
        end
        run_press_b();
    endtask

    task automatic test_reset_mid_step();
        wait_ready_a();
        valid_a = 1'b1; press_a = 1'b0; dir_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        checks++;
        if ({a_a, b_a} !== 2'b11) begin
            errors++;
            $display("FAIL mid_step_before_reset got %b%b want 11", a_a, b_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_a, b_a, c_a, done_a, ready_a} !== 5'b00001) begin
            errors++;
            $display("FAIL async_reset got %b want 00001", {a_a, b_a, c_a, done_a, ready_a});
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4 * PA + 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({a_a, b_a, done_a, ready_a} !== 4'b0001) begin
                errors++;
                $display("FAIL post_reset_idle i=%0d got %b want 0001", i, {a_a, b_a, done_a, ready_a});
            end
        end
        run_step_a(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_a = 1'b0; press_a = 1'b0; dir_a = 1'b0;
        valid_b = 1'b0; press_b = 1'b0; dir_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        test_cw_step();
        test_ccw_step();
        test_press();
        test_busy_ignored();
        test_back_to_back();
        test_bounce();
        test_reset_mid_step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotor_emulator.md
Name: rotor_emulator

Overview:
Synthesizable emulator of the Spartan-3E rotary shaft encoder. It drives ROT_A, ROT_B and ROT_CENTER waveforms, including optional contact bounce, into the rotor decoder in Top. A simple command handshake requests single detent steps (clockwise or counter-clockwise) or button presses. Benches use it as a cycle-accurate stimulus source. Boards without a physical rotor use it as a loopback source.

Parameters:
PHASE_CYCLES, 50000, clock cycles per quadrature phase (4 phases per detent step); must be >= 2
BOUNCE_CYCLES, 0, cycles of pseudo-random chatter at the start of each edge; 0 disables; must be < PHASE_CYCLES
PRESS_CYCLES, 500000, cycles ROT_CENTER is held high, and also the release gap that follows
LFSR_SEED, 16'hACE1, non-zero reset value of the bounce LFSR

Ports:
CLK50MHZ  in  1  system clock
RST  in  1  asynchronous reset, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high when a command can be accepted (idle)
cmd_press  in  1  1 = press/release centre button; 0 = rotate step
cmd_dir  in  1  1 = clockwise (A leads B); 0 = counter-clockwise (B leads A); ignored when cmd_press=1
done  out  1  one-cycle pulse when a command completes
ROT_A  out  1  quadrature line A
ROT_B  out  1  quadrature line B
ROT_CENTER  out  1  push-button line

Behaviour:
- Clock and reset: one clock domain, CLK50MHZ. Reset is asynchronous and active-low on RST.
- Reset (RST=0), effective immediately including mid-operation:
  - state=IDLE; ROT_A=0, ROT_B=0, ROT_CENTER=0.
  - cmd_ready=1 after release; done=0.
  - counter=0; LFSR=LFSR_SEED.
- All outputs are registered. Detent/idle level is A=B=CENTER=0.
- Accept rule: a command is accepted at a rising edge where cmd_valid & cmd_ready. cmd_ready equals (state==IDLE) and drops at that same edge. cmd_valid while busy is ignored; there is no queue.
- Rotate command, clockwise, target levels (A,B) per phase:
  - PH1 = (1,0)
  - PH2 = (1,1)
  - PH3 = (0,1)
  - PH4 = (0,0)
- Rotate command, counter-clockwise: the same sequence with A and B swapped.
- Press command: PRESS (CENTER target 1) for PRESS_CYCLES cycles, then RELEASE (target 0) for PRESS_CYCLES cycles.
- Rotate timing:
  - Accept at edge t0: outputs take PH1 levels at t0.
  - Each phase lasts exactly PHASE_CYCLES cycles.
  - At edge t0+4*PHASE_CYCLES: state=IDLE, done=1 for one cycle, cmd_ready=1.
  - A new command is accepted no earlier than that edge, so back-to-back commands have zero gap beyond the PH4 settle time.
- Press timing: done is pulsed at t0+2*PRESS_CYCLES.
- Counter: width clog2 of max(PHASE_CYCLES, PRESS_CYCLES). It resets to 0 on every state entry. The state advances when counter==limit-1.
- Bounce: when BOUNCE_CYCLES>0, for the first BOUNCE_CYCLES cycles of a state only the line changing in that state is driven with LFSR bit 0. From then on it holds the target level. The non-changing line is never disturbed.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle, regardless of state.
- Phase sequence integrity: exactly one line changes its settled level per phase (Gray sequence).
- Simultaneous events: cmd_press has priority over cmd_dir in the same command. A command and reset together: reset wins.

Decomposition:
- Package rotor_pkg holds:
  - state enum: IDLE, PH1, PH2, PH3, PH4, PRESS, RELEASE
  - DIR_CW=1, DIR_CCW=0
  - idle line level constant
  - clog2 helper function
- Sub-module rotor_lfsr16 (LFSR_SEED parameter; enable, out bit) produces the bounce chatter. The FSM, counter and output registers stay in rotor_emulator.

Test Plan:
- PHASE_CYCLES=4, BOUNCE_CYCLES=0; CW step accepted at t0 -> (A,B) = (1,0)@t0..t0+3, (1,1)@t0+4..7, (0,1)@t0+8..11, (0,0)@t0+12; done=1 and cmd_ready=1 @t0+16 only.
- Same parameters, CCW step -> B rises @t0, A rises @t0+4, B falls @t0+8, A falls @t0+12; Top decoder count decrements by exactly 1.
- PRESS_CYCLES=10; press command -> CENTER=1 for cycles t0..t0+9, 0 for t0+10..t0+19; done @t0+20; ROT_A/ROT_B stay 0 throughout.
- cmd_valid held high for 3 CW commands -> 3 contiguous 16-cycle sequences; Top decoder count +3; cmd_valid during busy causes no extra steps.
- BOUNCE_CYCLES=2, PHASE_CYCLES=8 -> only the changing line toggles in the first 2 cycles of each phase and is stable at target for the last 6; the other line stays constant; Top debouncer still counts exactly +1.
- RST pulled low at t0+6 of a CW step -> A=B=CENTER=0 and state=IDLE asynchronously; after release cmd_ready=1, no done pulse, and the next command runs a full sequence from PH1.
